// File: rtl/zap_wb_arbiter.sv
// N-master Wishbone B3 arbiter (fixed priority or round-robin). Grant is held for a
// whole cyc tenure; every downstream request output is registered.
module zap_wb_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_wen,
  input  logic [4*NUM_MASTERS-1:0]  i_m_wb_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_dat,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_adr,
  input  logic [3*NUM_MASTERS-1:0]  i_m_wb_cti,
  output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_wen,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_dat,
  output logic [31:0]               o_wb_adr,
  output logic [2:0]                o_wb_cti,
  input  logic                      i_wb_ack,
  output logic [NUM_MASTERS-1:0]    o_grant
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           g_q, g_d, p_q, p_d;
  logic [GW-1:0]           win, selIdx;
  logic                    found, load;
  int                      idx;
  logic                    wbCyc_q, wbCyc_d, wbStb_q, wbStb_d, wbWen_q, wbWen_d;
  logic [3:0]              wbSel_q, wbSel_d;
  logic [31:0]             wbDat_q, wbDat_d, wbAdr_q, wbAdr_d;
  logic [2:0]              wbCti_q, wbCti_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;

  logic [3:0]  mSel [NUM_MASTERS];
  logic [31:0] mDat [NUM_MASTERS];
  logic [31:0] mAdr [NUM_MASTERS];
  logic [2:0]  mCti [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign mSel[k] = i_m_wb_sel[4*k +: 4];
    assign mDat[k] = i_m_wb_dat[32*k +: 32];
    assign mAdr[k] = i_m_wb_adr[32*k +: 32];
    assign mCti[k] = i_m_wb_cti[3*k +: 3];
  end

  // Scan starts at p in round-robin mode and at 0 in fixed mode; first requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ARB_MODE == 1) idx = int'(p_q) + i;
      else               idx = i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && i_m_wb_cyc[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    load    = 1'b0;
    selIdx  = (state_q == IDLE) ? win : g_q;
    wbCyc_d = 1'b0;
    wbStb_d = 1'b0;
    wbWen_d = 1'b0;
    wbSel_d = '0;
    wbDat_d = '0;
    wbAdr_d = '0;
    wbCti_d = '0;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        if (|i_m_wb_cyc) begin
          state_d = BUSY;
          g_d     = win;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (i_m_wb_cyc[g_q]) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          if (ARB_MODE == 1) p_d = (g_q == GW'(NUM_MASTERS-1)) ? '0 : g_q + 1'b1;
        end
      end
    endcase
    if (load) begin
      wbCyc_d = i_m_wb_cyc[selIdx];
      wbStb_d = i_m_wb_stb[selIdx];
      wbWen_d = i_m_wb_wen[selIdx];
      wbSel_d = mSel[selIdx];
      wbDat_d = mDat[selIdx];
      wbAdr_d = mAdr[selIdx];
      wbCti_d = mCti[selIdx];
      grant_d = ONE << selIdx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
      wbCyc_q <= 1'b0;
      wbStb_q <= 1'b0;
      wbWen_q <= 1'b0;
      wbSel_q <= '0;
      wbDat_q <= '0;
      wbAdr_q <= '0;
      wbCti_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      wbCyc_q <= wbCyc_d;
      wbStb_q <= wbStb_d;
      wbWen_q <= wbWen_d;
      wbSel_q <= wbSel_d;
      wbDat_q <= wbDat_d;
      wbAdr_q <= wbAdr_d;
      wbCti_q <= wbCti_d;
      grant_q <= grant_d;
    end
  end

  // Acks reach only the current owner, and only while a cycle is actually on the bus.
  assign o_m_wb_ack = (i_wb_ack && (state_q == BUSY) && wbCyc_q && !i_reset) ? (ONE << g_q) : '0;

  assign o_wb_cyc = wbCyc_q;
  assign o_wb_stb = wbStb_q;
  assign o_wb_wen = wbWen_q;
  assign o_wb_sel = wbSel_q;
  assign o_wb_dat = wbDat_q;
  assign o_wb_adr = wbAdr_q;
  assign o_wb_cti = wbCti_q;
  assign o_grant  = grant_q;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter: a fixed-priority and a round-robin instance
// (4 masters each) share the same master-side stimulus.
module tb_zap_wb_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    mCyc, mStb, mWen;
  logic [4*N-1:0]  mSel;
  logic [32*N-1:0] mDat, mAdr;
  logic [3*N-1:0]  mCti;
  logic            wbAck;

  logic [N-1:0] fxAck, fxGrant, rrAck, rrGrant;
  logic         fxCyc, fxStb, fxWen, rrCyc, rrStb, rrWen;
  logic [3:0]   fxSel, rrSel;
  logic [31:0]  fxDat, fxAdr, rrDat, rrAdr;
  logic [2:0]   fxCti, rrCti;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zap_wb_arbiter #(.NUM_MASTERS(N), .ARB_MODE(0)) dutFixed (
    .i_clk(clk), .i_reset(reset),
    .i_m_wb_cyc(mCyc), .i_m_wb_stb(mStb), .i_m_wb_wen(mWen), .i_m_wb_sel(mSel),
    .i_m_wb_dat(mDat), .i_m_wb_adr(mAdr), .i_m_wb_cti(mCti), .o_m_wb_ack(fxAck),
    .o_wb_cyc(fxCyc), .o_wb_stb(fxStb), .o_wb_wen(fxWen), .o_wb_sel(fxSel),
    .o_wb_dat(fxDat), .o_wb_adr(fxAdr), .o_wb_cti(fxCti), .i_wb_ack(wbAck),
    .o_grant(fxGrant)
  );

  zap_wb_arbiter #(.NUM_MASTERS(N), .ARB_MODE(1)) dutRr (
    .i_clk(clk), .i_reset(reset),
    .i_m_wb_cyc(mCyc), .i_m_wb_stb(mStb), .i_m_wb_wen(mWen), .i_m_wb_sel(mSel),
    .i_m_wb_dat(mDat), .i_m_wb_adr(mAdr), .i_m_wb_cti(mCti), .o_m_wb_ack(rrAck),
    .o_wb_cyc(rrCyc), .o_wb_stb(rrStb), .o_wb_wen(rrWen), .o_wb_sel(rrSel),
    .o_wb_dat(rrDat), .o_wb_adr(rrAdr), .o_wb_cti(rrCti), .i_wb_ack(wbAck),
    .o_grant(rrGrant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic cyc, input logic stb, input logic wen,
                               input logic [3:0] sel, input logic [31:0] dat,
                               input logic [31:0] adr, input logic [2:0] cti);
    mCyc[k]          = cyc;
    mStb[k]          = stb;
    mWen[k]          = wen;
    mSel[4*k +: 4]   = sel;
    mDat[32*k +: 32] = dat;
    mAdr[32*k +: 32] = adr;
    mCti[3*k +: 3]   = cti;
  endtask

  task automatic clearMasters();
    mCyc = '0;
    mStb = '0;
    mWen = '0;
    mSel = '0;
    mDat = '0;
    mAdr = '0;
    mCti = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " fx cyc"},   32'(fxCyc),   32'h0);
    checkOutput({tag, " fx stb"},   32'(fxStb),   32'h0);
    checkOutput({tag, " fx adr"},   fxAdr,        32'h0);
    checkOutput({tag, " fx grant"}, 32'(fxGrant), 32'h0);
    checkOutput({tag, " rr cyc"},   32'(rrCyc),   32'h0);
    checkOutput({tag, " rr adr"},   rrAdr,        32'h0);
    checkOutput({tag, " rr grant"}, 32'(rrGrant), 32'h0);
  endtask

  task automatic checkBus(input string tag, input logic [3:0] grantExp, input logic [31:0] adrExp);
    checkOutput({tag, " fx grant"}, 32'(fxGrant), 32'(grantExp));
    checkOutput({tag, " fx cyc"},   32'(fxCyc),   32'h1);
    checkOutput({tag, " fx adr"},   fxAdr,        adrExp);
    checkOutput({tag, " rr grant"}, 32'(rrGrant), 32'(grantExp));
    checkOutput({tag, " rr adr"},   rrAdr,        adrExp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [3:0] expGrant;
    reset = 1'b1;
    wbAck = 1'b0;
    clearMasters();
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 1'b1, 1'b1, 4'hF, 32'hA5A5_0000, 32'h1000_0000 | 32'(k), 3'b010);

    // Reset held two cycles with every master requesting
    tick();
    checkIdle("reset1");
    checkOutput("reset fx sel", 32'(fxSel), 32'h0);
    checkOutput("reset fx dat", fxDat,      32'h0);
    checkOutput("reset fx cti", 32'(fxCti), 32'h0);
    checkOutput("reset fx wen", 32'(fxWen), 32'h0);
    wbAck = 1'b1;
    #1;
    checkOutput("reset fx ack", 32'(fxAck), 32'h0);
    checkOutput("reset rr ack", 32'(rrAck), 32'h0);
    wbAck = 1'b0;
    tick();
    checkIdle("reset2");
    reset = 1'b0;
    tick();
    checkBus("first grant", 4'b0001, 32'h1000_0000);

    // Reset in the middle of a tenure
    wbAck = 1'b1;
    #1;
    checkOutput("tenure fx ack", 32'(fxAck), 32'h1);
    checkOutput("tenure rr ack", 32'(rrAck), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midreset fx ack", 32'(fxAck), 32'h0);
    checkOutput("midreset rr ack", 32'(rrAck), 32'h0);
    tick();
    checkIdle("midreset");
    reset = 1'b0;
    wbAck = 1'b0;
    clearMasters();
    tick();
    checkIdle("postreset");

    // Single master with a one-ack tenure
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0000_1000, 3'b000);
    tick();
    checkBus("single", 4'b0010, 32'h0000_1000);
    checkOutput("single fx sel", 32'(fxSel), 32'hF);
    checkOutput("single fx dat", fxDat,      32'hCAFE_F00D);
    checkOutput("single fx wen", 32'(fxWen), 32'h1);
    checkOutput("single fx cti", 32'(fxCti), 32'h0);
    wbAck = 1'b1;
    #1;
    checkOutput("single fx ack", 32'(fxAck), 32'b0010);
    checkOutput("single rr ack", 32'(rrAck), 32'b0010);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();
    wbAck = 1'b0;
    #1;
    checkOutput("single ack after", 32'(rrAck), 32'h0);
    checkIdle("single end");

    // Round-robin rotation with all masters requesting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h1000_0000 | 32'(k), 3'b000);
    tick();
    for (int t = 0; t < N; t++) begin
      expGrant = 4'b0001 << t;
      checkOutput("rr grant", 32'(rrGrant), 32'(expGrant));
      checkOutput("rr adr",   rrAdr,        32'h1000_0000 | 32'(t));
      wbAck = 1'b1;
      #1;
      checkOutput("rr ack", 32'(rrAck), 32'(expGrant));
      mCyc[t] = 1'b0;
      tick();
      wbAck = 1'b0;
      checkOutput("rr gap grant", 32'(rrGrant), 32'h0);
      mCyc[t] = 1'b1;
      tick();
    end
    checkOutput("rr wrap grant", 32'(rrGrant), 32'b0001);

    // Fixed priority: masters 0 and 2 compete
    reset = 1'b1;
    clearMasters();
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h1000_0000, 3'b000);
    applyStimulus(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h1000_0002, 3'b000);
    tick();
    checkBus("prio first", 4'b0001, 32'h1000_0000);
    wbAck = 1'b1;
    mCyc[0] = 1'b0;
    tick();
    wbAck = 1'b0;
    checkOutput("prio gap fx", 32'(fxGrant), 32'h0);
    checkOutput("prio gap rr", 32'(rrGrant), 32'h0);
    mCyc[0] = 1'b1;
    tick();
    checkOutput("prio second fx", 32'(fxGrant), 32'b0001);
    checkOutput("prio second rr", 32'(rrGrant), 32'b0100);
    checkOutput("prio second rr adr", rrAdr, 32'h1000_0002);
    wbAck = 1'b1;
    #1;
    checkOutput("prio fx ack", 32'(fxAck), 32'b0001);
    checkOutput("prio rr ack", 32'(rrAck), 32'b0100);
    mCyc[0] = 1'b0;
    tick();
    wbAck = 1'b0;
    checkOutput("prio release fx", 32'(fxGrant), 32'h0);
    checkOutput("prio hold rr",    32'(rrGrant), 32'b0100);
    tick();
    checkOutput("prio m2 fx", 32'(fxGrant), 32'b0100);
    checkOutput("prio m2 fx adr", fxAdr, 32'h1000_0002);
    clearMasters();
    tick();
    checkIdle("prio end");

    // 16-beat burst from master 1 with a 3-cycle stb gap; master 0 waits
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_2000, 3'b010);
    tick();
    for (int b = 0; b < 16; b++) begin
      checkBus("burst beat", 4'b0010, 32'h0000_2000 + 32'(4*b));
      checkOutput("burst stb", 32'(fxStb), 32'h1);
      checkOutput("burst cti", 32'(fxCti), (b == 15) ? 32'h7 : 32'h2);
      wbAck = 1'b1;
      #1;
      checkOutput("burst fx ack", 32'(fxAck), 32'b0010);
      if (b == 4) applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_3000, 3'b000);
      if (b == 7) begin
        mStb[1] = 1'b0;
        tick();
        wbAck = 1'b0;
        for (int g = 0; g < 3; g++) begin
          checkOutput("burst gap stb",   32'(fxStb),   32'h0);
          checkOutput("burst gap fx",    32'(fxGrant), 32'b0010);
          checkOutput("burst gap rr",    32'(rrGrant), 32'b0010);
          if (g == 2) applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_2020, 3'b010);
          tick();
        end
      end else if (b < 15) begin
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_2000 + 32'(4*(b+1)),
                      (b + 1 == 15) ? 3'b111 : 3'b010);
        tick();
        wbAck = 1'b0;
      end else begin
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000);
        tick();
        wbAck = 1'b0;
      end
    end
    checkIdle("burst end");
    tick();
    checkBus("after burst", 4'b0001, 32'h0000_3000);
    wbAck = 1'b1;
    mCyc[0] = 1'b0;
    tick();
    wbAck = 1'b0;
    checkIdle("m0 end");

    // Stray ack while idle
    wbAck = 1'b1;
    #1;
    checkOutput("stray fx ack", 32'(fxAck), 32'h0);
    checkOutput("stray rr ack", 32'(rrAck), 32'h0);
    tick();
    checkIdle("stray");
    wbAck = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_wb_arbiter.md
# zap_wb_arbiter

N-master Wishbone B3 arbiter that generalises the two-port cache merger to `NUM_MASTERS` channels, with selectable fixed-priority or round-robin arbitration. It sits between the per-master `_nxt`-style request outputs (code cache, data cache, future DMA/PTW masters) and the store-buffer Wishbone adapter. Grant is held for a whole bus tenure, i.e. while the granted master keeps `cyc` asserted, so bursts are never split. All downstream request outputs are registered.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of masters; legal range 2..16.
- `ARB_MODE`, 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.

Ports:
- `i_clk`  in  1  clock; one clock domain. Reset is synchronous and active-high.
- `i_reset`  in  1  synchronous active-high reset.
- `i_m_wb_cyc`  in  NUM_MASTERS  per-master cyc (next-cycle value); bit k belongs to master k.
- `i_m_wb_stb`  in  NUM_MASTERS  per-master stb (next).
- `i_m_wb_wen`  in  NUM_MASTERS  per-master write enable (next).
- `i_m_wb_sel`  in  4*NUM_MASTERS  byte selects; master k uses [4k+3:4k].
- `i_m_wb_dat`  in  32*NUM_MASTERS  write data; master k uses [32k+31:32k].
- `i_m_wb_adr`  in  32*NUM_MASTERS  address; master k uses [32k+31:32k].
- `i_m_wb_cti`  in  3*NUM_MASTERS  cycle type; master k uses [3k+2:3k].
- `o_m_wb_ack`  out  NUM_MASTERS  per-master ack, combinational.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_wen`  out  1 each  registered downstream controls.
- `o_wb_sel`  out  4  registered.
- `o_wb_dat`  out  32  registered.
- `o_wb_adr`  out  32  registered.
- `o_wb_cti`  out  3  registered.
- `i_wb_ack`  in  1  downstream ack.
- `o_grant`  out  NUM_MASTERS  registered one-hot of the current owner; all zeros when idle.

Read data is not carried by this block; masters take it directly from the shared downstream data bus.

## Operation
- State machine: IDLE, BUSY. Registers: state, grant index `g` (clog2(NUM_MASTERS) bits), round-robin pointer `p`.
- **IDLE, no `i_m_wb_cyc` bit set:** all registered outputs are loaded with 0.
- **IDLE, any bit set:**
  - Winner `w` is chosen per `ARB_MODE`.
    - Fixed priority: the lowest set index.
    - Round-robin: the first set index scanning upward from `p`, wrapping from NUM_MASTERS-1 to 0.
  - Set `g`←`w` and state←BUSY.
  - Load the outputs from master `w`'s inputs; `o_grant`←onehot(`w`).
- **BUSY, `i_m_wb_cyc[g]`=1:** load the outputs from master `g` every cycle. `stb` may drop while `cyc` stays high; the grant is still held (locked transfer, burst gaps).
- **BUSY, `i_m_wb_cyc[g]`=0 (tenure end):**
  - Load all outputs with 0, state←IDLE, `o_grant`←0.
  - In round-robin mode, `p`←(`g`+1) mod NUM_MASTERS; in fixed mode `p` is unused and stays 0.
- Other masters' request changes during BUSY are ignored.
- `o_m_wb_ack[k]` = `i_wb_ack` & (state==BUSY) & (`g`==k) & `o_wb_cyc` & !`i_reset`.
- An `i_wb_ack` arriving in IDLE, or while `o_wb_cyc`=0, is dropped and never reaches any master.

## Timing
- **Reset (edge with `i_reset`=1):**
  - state=IDLE, `g`=0, `p`=0.
  - All outputs 0: `o_wb_cyc/stb/wen`=0, `o_wb_sel`=0, `o_wb_dat`=0, `o_wb_adr`=0, `o_wb_cti`=0, `o_grant`=0.
  - `o_m_wb_ack`=0 while `i_reset` is high.
- **Reset mid-tenure:** the bus drops on the next edge; the master's ack is suppressed in the reset cycle itself.
- **Grant latency:** a request sampled in IDLE at edge t appears on `o_wb_*` after edge t.
- **Re-arbitration:** the edge that samples `cyc`=0 clears the bus; the next arbitration happens at the following edge. This gives one bus-idle cycle between tenures, the minimum.
- **Ack path:** `i_wb_ack` to `o_m_wb_ack` is combinational, zero cycles. The master updates its next-state inputs in the same cycle.
- **Round-robin fairness:** with all masters continuously requesting, each waits at most NUM_MASTERS-1 tenures.

## Test plan
- **Reset:** assert `i_reset` for 2 cycles with all `cyc` high, NUM_MASTERS=4 -> every output is 0 and `o_grant`=0. First grant goes to master 0 one cycle after reset drops.
- **Single master:** master 1 drives `cyc`=`stb`=1, adr=0x0000_1000, sel=0xF, cti=000. Downstream pulses `i_wb_ack` for one cycle -> next cycle `o_wb_adr`=0x0000_1000, `o_grant`=0b0010. `o_m_wb_ack`=0b0010 in the ack cycle only.
- **Round-robin:** ARB_MODE=1, four masters each request with one-ack tenures (drop `cyc` the cycle after ack) -> `o_grant` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- **Fixed priority:** ARB_MODE=0, masters 0 and 2 request repeatedly -> master 0 wins every arbitration. Master 2 is granted only in an IDLE cycle where `cyc[0]`=0.
- **Burst hold:** master 1 issues a 16-beat burst at 0x2000, cti=010 ending with 111, with stb low for 3 cycles mid-burst. Master 0 requests at beat 4 -> grant stays 0b0010 through all 16 acks and the stb gap. Master 0 is granted 2 cycles after master 1 drops `cyc`.
- **Stray ack:** pulse `i_wb_ack` while IDLE -> `o_m_wb_ack` stays 0 and state is unchanged.
